// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
//   mul_op_t      : operation encoding (MUL, MULH, MULHSU, MULHU)
//   mul_state_t   : multiplier control FSM states
//   BOOTH_GROUP_W : width of one recoded multiplier group
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int BOOTH_GROUP_W = 3;

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth partial product selector (purely combinational).
// Ports:
//   a   : XLEN+2-bit extended multiplicand (two's complement)
//   grp : 3-bit multiplier group {b[2k+1], b[2k], b[2k-1]}
//   pp  : XLEN+3-bit signed partial product in {0, +A, +2A, -A, -2A}
module booth_pp_sel
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        [XLEN+1:0]          a,
  input  logic        [BOOTH_GROUP_W-1:0] grp,
  output logic signed [XLEN+2:0]          pp
);

  logic signed [XLEN+2:0] a_x;

  always_comb begin
    // One extra sign bit so that 2A cannot overflow.
    a_x = {a[XLEN+1], a};
    case (grp)
      3'b001, 3'b010: pp = a_x;
      3'b011:         pp = a_x <<< 1;
      3'b100:         pp = -(a_x <<< 1);
      3'b101, 3'b110: pp = -a_x;
      default:        pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, one recoded group per clock.
// Ports:
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_valid / o_ready    : request handshake (i_op, i_data_a, i_data_b)
//   i_flush              : abort any operation in flight
//   o_valid / i_ready    : result handshake (o_data)
//   o_busy               : high whenever the FSM is not IDLE
// Optional feature: define BOOTH_MUL_ZERO_SKIP_EN to finish a request with a
// zero operand in one cycle instead of running the full iteration count.
module booth_mul_seq
  import mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = (XLEN + 2) / 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_data_a,
  input  logic [XLEN-1:0] i_data_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_data,
  output logic            o_busy
);

  localparam int EXT_W = XLEN + 2;
  localparam int PP_W  = XLEN + 3;
  localparam int ACC_W = 2 * EXT_W;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  mul_state_t        state_q;
  mul_op_t           op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [EXT_W-1:0]  a_q;
  // Multiplier with an appended 0 (bit -1); shifted right by 2 each cycle so
  // the current group is always the low three bits.
  logic [EXT_W:0]    mplr_q;
  logic [ACC_W-1:0]  acc_q;

  logic              sign_a;
  logic              sign_b;
  logic [EXT_W-1:0]  a_ext;
  logic [EXT_W-1:0]  b_ext;
  logic              skip;
  logic signed [PP_W-1:0] pp;
  logic [ACC_W-1:0]  term;
  logic [ACC_W-1:0]  acc_next;
  logic [XLEN-1:0]   res_sel;
  logic              last_iter;

  booth_pp_sel #(
    .XLEN (XLEN)
  ) u_pp_sel (
    .a   (a_q),
    .grp (mplr_q[BOOTH_GROUP_W-1:0]),
    .pp  (pp)
  );

  always_comb begin
    sign_a = (i_op != MULHU);
    sign_b = (i_op == MUL) || (i_op == MULH);
    a_ext  = {{2{sign_a & i_data_a[XLEN-1]}}, i_data_a};
    b_ext  = {{2{sign_b & i_data_b[XLEN-1]}}, i_data_b};
  end

`ifdef BOOTH_MUL_ZERO_SKIP_EN
  always_comb skip = (i_data_a == '0) || (i_data_b == '0);
`else
  always_comb skip = 1'b0;
`endif

  always_comb begin
    term      = {{(ACC_W - PP_W){pp[PP_W-1]}}, pp} << {cnt_q, 1'b0};
    acc_next  = acc_q + term;
    res_sel   = (op_q == MUL) ? acc_next[XLEN-1:0] : acc_next[2*XLEN-1:XLEN];
    last_iter = (cnt_q == CNT_W'(ITER - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      op_q    <= MUL;
      cnt_q   <= '0;
      a_q     <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_data  <= '0;
    end else if (i_flush) begin
      state_q <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_data  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            op_q    <= mul_op_t'(i_op);
            a_q     <= a_ext;
            mplr_q  <= {b_ext, 1'b0};
            cnt_q   <= '0;
            acc_q   <= '0;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
            if (skip) begin
              state_q <= DONE;
              o_valid <= 1'b1;
              o_data  <= '0;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q  <= acc_next;
          mplr_q <= mplr_q >> 2;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            // Result is taken from the final sum so it is valid on DONE entry.
            state_q <= DONE;
            o_valid <= 1'b1;
            o_data  <= res_sel;
          end
        end
        DONE: begin
          if (i_ready) begin
            state_q <= IDLE;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_data  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq (XLEN=32): directed corner cases,
// flush/reset aborts and randomized operations against an arithmetic model.
module tb_booth_mul_seq;
  import mul_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [31:0] i_data_a;
  logic [31:0] i_data_b;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  booth_mul_seq #(
    .XLEN (32)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_data_a (i_data_a),
    .i_data_b (i_data_b),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: exact product of the extended operands, then word select.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [65:0] ea, eb, p;
    ea = (op == 2'(MULHU)) ? {34'b0, a} : {{34{a[31]}}, a};
    eb = (op == 2'(MUL) || op == 2'(MULH)) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = ea * eb;
    return (op == 2'(MUL)) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = 18;
`ifdef BOOTH_MUL_ZERO_SKIP_EN
    if (a == 32'd0 || b == 32'd0) lat = 1;
`endif
    return lat;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_busy"},  32'(o_busy),  32'd0);
    check({tag, "_data"},  o_data,       32'd0);
  endtask

  // Accept one request at a posedge; leaves the DUT just after that edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge i_clk);
    check("req_ready", 32'(o_ready), 32'd1);
    i_valid  = 1'b1;
    i_op     = op;
    i_data_a = a;
    i_data_b = b;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    int n;
    logic [31:0] exp;
    exp = ref_mul(op, a, b);
    i_ready = 1'b0;
    issue(op, a, b);
    n = 1;
    while (!o_valid && n < 64) begin
      if (n == 2) begin
        check("calc_busy", 32'(o_busy), 32'd1);
        check("calc_data", o_data, 32'd0);
      end
      @(posedge i_clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(exp_latency(a, b)));
    check("result", o_data, exp);
    repeat (hold) begin
      @(posedge i_clk);
      #1;
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_data",  o_data,       exp);
      check("hold_ready", 32'(o_ready), 32'd0);
    end
    @(negedge i_clk);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    check_idle("post_hs");
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge i_clk);
      #1;
      if (o_valid) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    i_rst = 1'b1; i_valid = 1'b0; i_op = 2'd0; i_data_a = '0; i_data_b = '0;
    i_flush = 1'b0; i_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_idle("reset");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Directed corner cases
    run_op(2'(MUL),    32'd7,        32'hFFFF_FFFD, 0);
    run_op(2'(MULH),   32'h8000_0000, 32'h8000_0000, 0);
    run_op(2'(MULHU),  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'(MULHSU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'(MUL),    32'd0,        32'd5,         0);
    run_op(2'(MULHU),  32'd9,        32'd0,         1);
    run_op(2'(MULH),   32'h1234_5678, 32'h9ABC_DEF0, 5);

    // Flush and valid together in IDLE: flush wins, nothing accepted
    @(negedge i_clk);
    i_valid = 1'b1; i_flush = 1'b1; i_op = 2'(MUL); i_data_a = 32'd3; i_data_b = 32'd4;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0; i_flush = 1'b0;
    check_idle("flush_idle");

    // Flush at CALC counter 8
    issue(2'(MUL), 32'd11, 32'd13);
    repeat (8) @(posedge i_clk);
    #1;
    check("pre_flush_busy", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    check_idle("flush_calc");
    watch_no_valid("flush_no_valid", 25);

    // Reset in CALC, with a simultaneous flush (reset has priority anyway)
    issue(2'(MULHSU), 32'h8765_4321, 32'h0F0F_0F0F);
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1; i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0; i_flush = 1'b0;
    check_idle("rst_calc");
    watch_no_valid("rst_no_valid", 25);

    // Flush while in DONE drops the result
    issue(2'(MUL), 32'd100, 32'd200);
    repeat (20) @(posedge i_clk);
    #1;
    check("done_valid", 32'(o_valid), 32'd1);
    @(negedge i_clk);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    check_idle("flush_done");

    // New request after aborts completes correctly
    run_op(2'(MULH), 32'hDEAD_BEEF, 32'hCAFE_F00D, 2);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       a = 32'd0;
        1:       a = 32'h8000_0000;
        2:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'h7FFF_FFFF;
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op(op, a, b, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mul_seq.md
BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width in bits.
REQ-002 SHALL have parameter ITER, default (XLEN+2)/2, number of radix-4 Booth iterations.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port i_valid, input, 1, request valid.
REQ-006 SHALL have port o_ready, output, 1, request accepted when i_valid && o_ready.
REQ-007 SHALL have port i_op, input, 2, operation: MUL, MULH, MULHSU, MULHU (mul_op_t).
REQ-008 SHALL have ports i_data_a and i_data_b, input, XLEN each, multiplicand (rs1) and multiplier (rs2).
REQ-009 SHALL have port i_flush, input, 1, abort any operation in flight.
REQ-010 SHALL have ports o_valid, output, 1, result valid; i_ready, input, 1, result consumed when o_valid && i_ready.
REQ-011 SHALL have ports o_data, output, XLEN, result; o_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 SHALL drive o_ready high only in IDLE.
REQ-014 SHALL, on accept, latch i_op and extend both operands to XLEN+2 bits: MUL/MULH sign-extend both; MULHSU sign-extend a, zero-extend b; MULHU zero-extend both. SHALL then enter CALC with the iteration counter at 0.
REQ-015 SHALL, each CALC cycle, recode one 3-bit multiplier group (bits 2k+1, 2k, 2k-1; bit -1 = 0) into {0, +A, +2A, -A, -2A}. SHALL add the term, shifted 2k, into a 2*(XLEN+2)-bit accumulator using two's complement modulo the accumulator width.
REQ-016 SHALL increment the counter each CALC cycle and move to DONE after the cycle with counter == ITER-1, so o_valid rises exactly ITER+1 cycles after the accept edge (18 for XLEN=32).
REQ-017 SHALL, in DONE, hold o_valid high and o_data stable until i_ready. o_data = product[XLEN-1:0] for MUL and product[2*XLEN-1:XLEN] otherwise.
REQ-018 SHALL return to IDLE on the edge where o_valid && i_ready, with o_ready high the following cycle; no same-cycle accept in DONE.
REQ-019 SHALL, on i_flush in any state, enter IDLE next edge and drop o_valid. When i_flush and i_valid coincide in IDLE, flush wins and nothing is accepted.
REQ-020 SHALL drive o_data to 0 whenever o_valid is low.

Reset
REQ-021 SHALL, on i_rst high at a clock edge, enter IDLE and clear the counter, accumulator and latched op. Outputs SHALL be o_ready=1, o_valid=0, o_busy=0, o_data=0.
REQ-022 SHALL give i_rst priority over i_flush and every handshake. Reset mid-CALC or in DONE SHALL discard the operation with no result produced.

Configuration
REQ-023 SHALL support macro BOOTH_MUL_ZERO_SKIP_EN.
REQ-024 With BOOTH_MUL_ZERO_SKIP_EN defined, an accepted request with i_data_a == 0 or i_data_b == 0 SHALL go straight to DONE with o_data = 0; o_valid rises 1 cycle after accept.
REQ-025 Without BOOTH_MUL_ZERO_SKIP_EN, every request SHALL take the full ITER+1 cycles.

Structure
REQ-026 SHALL place mul_op_t (MUL=0, MULH=1, MULHSU=2, MULHU=3), the FSM state enum and the constant BOOTH_GROUP_W=3 in the shared package mul_pkg.
REQ-027 SHALL instantiate one combinational sub-module booth_pp_sel. It takes A and the 3-bit group and outputs the XLEN+3-bit signed partial product.

Verification
REQ-028 MUL a=7, b=-3 -> o_data=0xFFFFFFEB at cycle 18 after accept.
REQ-029 MULH a=b=0x80000000 -> o_data=0x40000000; MULHU a=b=0xFFFFFFFF -> o_data=0xFFFFFFFE.
REQ-030 MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> o_data=0xFFFFFFFF.
REQ-031 Hold i_ready low 5 cycles in DONE -> o_valid and o_data stable; o_ready low until 1 cycle after the i_ready handshake.
REQ-032 Assert i_flush at CALC counter 8, then i_rst in a later CALC -> each returns to IDLE next edge with no o_valid pulse. A new request afterwards SHALL complete correctly.
REQ-033 MUL a=0, b=5: with BOOTH_MUL_ZERO_SKIP_EN -> o_valid after 1 cycle, o_data=0; without -> after 18 cycles, o_data=0.
